// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } mem_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    // Byte loads never fault; encodings 3, 6 and 7 are word-sized like LW.
    function automatic logic load_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        case (funct3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return addr_lo[0];
            default:       return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// Extracts and extends the addressed byte/halfword of a returned load word.
module mem_access_stage_load_formatter
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] drdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [15:0] lane;

    assign lane = 16'(drdata_i >> {addr_lo_i, 3'b000});

    always_comb begin
        case (funct3_i)
            F3_LB:   result_o = {{24{lane[7]}}, lane[7:0]};
            F3_LBU:  result_o = {24'h0, lane[7:0]};
            F3_LH:   result_o = {{16{lane[15]}}, lane};
            F3_LHU:  result_o = {16'h0, lane};
            F3_LW:   result_o = drdata_i;
            default: result_o = drdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the handshaked data bus, stalls upstream while an access
// is outstanding, formats load data and registers the MEM/WB bundle.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter logic [6:0]  LOAD_OPCODE    = OP_LOAD,
    parameter int unsigned RVALID_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  EM_op_in,
    input  logic [2:0]  EM_funct3_in,
    input  logic [31:0] EM_daddr_in,
    input  logic [3:0]  EM_we_in,
    input  logic        EM_wer_in,
    input  logic [4:0]  EM_rd_in,
    input  logic [31:0] EM_regdata_in,
    input  logic [31:0] EM_dwdata_in,
    output logic        dreq,
    output logic [31:0] daddr,
    output logic        dwe,
    output logic [3:0]  dbe,
    output logic [31:0] dwdata,
    input  logic        dgnt,
    input  logic        drvalid,
    input  logic [31:0] drdata,
    output logic        mem_stall,
    output logic        MW_wer_out,
    output logic [4:0]  MW_rd_out,
    output logic [31:0] MW_wbdata_out,
    output logic        mem_misalign_out,
    output logic        mem_buserr_out
);

    localparam int unsigned CNT_W = (RVALID_TIMEOUT > 1) ? $clog2(RVALID_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(RVALID_TIMEOUT);
    localparam bit TIMEOUT_EN = (RVALID_TIMEOUT != 0);

    mem_state_e       state_q, state_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             mw_wer_q, mw_wer_d;
    logic [4:0]       mw_rd_q, mw_rd_d;
    logic [31:0]      mw_wbdata_q, mw_wbdata_d;
    logic             misalign_q, misalign_d;
    logic             buserr_q, buserr_d;

    logic        is_store, load_access, load_misalign, access_req;
    logic [31:0] load_result;

    // A store byte-enable overrides a load opcode on the same instruction.
    assign is_store      = |EM_we_in;
    assign load_access   = (EM_op_in == LOAD_OPCODE) && EM_wer_in && !is_store;
    assign load_misalign = load_access && load_misaligned(EM_funct3_in, EM_daddr_in[1:0]);
    assign access_req    = is_store || (load_access && !load_misalign);
    assign cnt_inc       = cnt_q + CNT_W'(1);

    assign daddr  = {EM_daddr_in[31:2], 2'b00};
    assign dwdata = EM_dwdata_in;
    assign dbe    = is_store ? EM_we_in : 4'hF;
    assign dwe    = dreq && is_store;

    mem_access_stage_load_formatter u_load_formatter (
        .drdata_i  (drdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .result_o  (load_result)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        cnt_d       = '0;
        mw_wer_d    = 1'b0;
        mw_rd_d     = mw_rd_q;
        mw_wbdata_d = mw_wbdata_q;
        misalign_d  = 1'b0;
        buserr_d    = 1'b0;
        dreq        = 1'b0;
        mem_stall   = 1'b0;

        case (state_q)
            IDLE, WAIT_GNT: begin
                if (access_req) begin
                    dreq      = 1'b1;
                    addr_lo_d = EM_daddr_in[1:0];
                    funct3_d  = EM_funct3_in;
                    rd_d      = EM_rd_in;
                    if (!dgnt) begin
                        state_d   = WAIT_GNT;
                        mem_stall = 1'b1;
                    end else if (is_store) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = WAIT_RVALID;
                        mem_stall = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    if (load_misalign) begin
                        misalign_d = 1'b1;
                    end else begin
                        mw_wer_d    = EM_wer_in;
                        mw_rd_d     = EM_rd_in;
                        mw_wbdata_d = EM_regdata_in;
                    end
                end
            end

            WAIT_RVALID: begin
                cnt_d = cnt_inc;
                if (drvalid) begin
                    state_d     = IDLE;
                    mw_wer_d    = 1'b1;
                    mw_rd_d     = rd_q;
                    mw_wbdata_d = load_result;
                end else begin
                    mem_stall = 1'b1;
                    // Abort is not a completion, so stall holds through this last cycle.
                    if (TIMEOUT_EN && cnt_inc == TIMEOUT_VAL) begin
                        state_d  = IDLE;
                        buserr_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            mw_wer_q    <= 1'b0;
            mw_rd_q     <= '0;
            mw_wbdata_q <= '0;
            misalign_q  <= 1'b0;
            buserr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            mw_wer_q    <= mw_wer_d;
            mw_rd_q     <= mw_rd_d;
            mw_wbdata_q <= mw_wbdata_d;
            misalign_q  <= misalign_d;
            buserr_q    <= buserr_d;
        end
    end

    assign MW_wer_out       = mw_wer_q;
    assign MW_rd_out        = mw_rd_q;
    assign MW_wbdata_out    = mw_wbdata_q;
    assign mem_misalign_out = misalign_q;
    assign mem_buserr_out   = buserr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, randomized transactions
// against a transaction-level model, and a mid-transaction reset sequence.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int TO = 4;
    localparam int K_ALU = 0, K_STORE = 1, K_LOAD = 2, K_MIS = 3;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [3:0]  we;
        logic        wer;
        logic [4:0]  rd;
        logic [31:0] regdata;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        int          kind;
        logic        exp_wer;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wb;
        logic        exp_mis;
        logic        exp_berr;
    } vec_t;

    logic        clk, rst_n;
    logic [6:0]  EM_op_in;
    logic [2:0]  EM_funct3_in;
    logic [31:0] EM_daddr_in;
    logic [3:0]  EM_we_in;
    logic        EM_wer_in;
    logic [4:0]  EM_rd_in;
    logic [31:0] EM_regdata_in, EM_dwdata_in;
    logic        dreq, dwe, dgnt, drvalid, mem_stall;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dbe;
    logic        MW_wer_out, mem_misalign_out, mem_buserr_out;
    logic [4:0]  MW_rd_out;
    logic [31:0] MW_wbdata_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage #(.LOAD_OPCODE(OP_LOAD), .RVALID_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .EM_op_in(EM_op_in), .EM_funct3_in(EM_funct3_in), .EM_daddr_in(EM_daddr_in),
        .EM_we_in(EM_we_in), .EM_wer_in(EM_wer_in), .EM_rd_in(EM_rd_in),
        .EM_regdata_in(EM_regdata_in), .EM_dwdata_in(EM_dwdata_in),
        .dreq(dreq), .daddr(daddr), .dwe(dwe), .dbe(dbe), .dwdata(dwdata),
        .dgnt(dgnt), .drvalid(drvalid), .drdata(drdata), .mem_stall(mem_stall),
        .MW_wer_out(MW_wer_out), .MW_rd_out(MW_rd_out), .MW_wbdata_out(MW_wbdata_out),
        .mem_misalign_out(mem_misalign_out), .mem_buserr_out(mem_buserr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Load result from the architectural rule: shift the word down to the addressed byte.
    function automatic logic [31:0] ref_fmt(input logic [31:0] rdata, input logic [1:0] lo,
                                            input logic [2:0] f3);
        logic [31:0] w;
        w = rdata >> (int'(lo) * 8);
        case (f3)
            3'd0:    return 32'($signed(w[7:0]));
            3'd4:    return {24'h0, w[7:0]};
            3'd1:    return 32'($signed(w[15:0]));
            3'd5:    return {16'h0, w[15:0]};
            default: return rdata;
        endcase
    endfunction

    function automatic vec_t model(input vec_t v);
        int   size;
        logic st, ld;
        st   = (v.we != 4'h0);
        ld   = (v.op == OP_LOAD) && v.wer;
        size = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
        v.exp_wer = 1'b0; v.exp_rd = '0; v.exp_wb = '0; v.exp_mis = 1'b0; v.exp_berr = 1'b0;
        if (st) begin
            v.kind = K_STORE;
        end else if (ld && (v.addr % 32'(size)) != 0) begin
            v.kind = K_MIS;
            v.exp_mis = 1'b1;
        end else if (ld) begin
            v.kind = K_LOAD;
            if (v.rv_dly < TO) begin
                v.exp_wer = 1'b1;
                v.exp_rd  = v.rd;
                v.exp_wb  = ref_fmt(v.rdata, v.addr[1:0], v.f3);
            end else begin
                v.exp_berr = 1'b1;
            end
        end else begin
            v.kind    = K_ALU;
            v.exp_wer = v.wer;
            v.exp_rd  = v.rd;
            v.exp_wb  = v.regdata;
        end
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int   sel;
        sel       = $urandom_range(0, 2);
        v.op      = 7'($urandom);
        v.f3      = 3'($urandom);
        v.addr    = $urandom;
        v.we      = 4'h0;
        v.wer     = 1'($urandom);
        v.rd      = 5'($urandom);
        v.regdata = $urandom;
        v.wdata   = $urandom;
        v.rdata   = $urandom;
        v.gnt_dly = $urandom_range(0, 3);
        v.rv_dly  = $urandom_range(0, TO + 1);
        case (sel)
            0: if (v.op == OP_LOAD) v.op = 7'h33;
            1: v.we = 4'($urandom_range(1, 15));
            default: begin
                v.op  = OP_LOAD;
                v.wer = 1'b1;
                if (v.f3 inside {3'd3, 3'd6, 3'd7}) v.addr[1:0] = 2'b00;
            end
        endcase
        return model(v);
    endfunction

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [3:0] we, input logic wer, input logic [4:0] rd,
                                input logic [31:0] regdata, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gnt, input int rv, input int kind,
                                input logic ewer, input logic [4:0] erd, input logic [31:0] ewb,
                                input logic emis, input logic eberr);
        vec_t v;
        v.op = op; v.f3 = f3; v.addr = addr; v.we = we; v.wer = wer; v.rd = rd;
        v.regdata = regdata; v.wdata = wdata; v.rdata = rdata; v.gnt_dly = gnt; v.rv_dly = rv;
        v.kind = kind; v.exp_wer = ewer; v.exp_rd = erd; v.exp_wb = ewb;
        v.exp_mis = emis; v.exp_berr = eberr;
        return v;
    endfunction

    task automatic drive_idle();
        EM_op_in = '0; EM_funct3_in = '0; EM_daddr_in = '0; EM_we_in = '0;
        EM_wer_in = 1'b0; EM_rd_in = '0; EM_regdata_in = '0; EM_dwdata_in = '0;
    endtask

    task automatic drive_em(input vec_t v);
        EM_op_in = v.op; EM_funct3_in = v.f3; EM_daddr_in = v.addr; EM_we_in = v.we;
        EM_wer_in = v.wer; EM_rd_in = v.rd; EM_regdata_in = v.regdata; EM_dwdata_in = v.wdata;
    endtask

    task automatic run_txn(input vec_t v);
        logic hit;
        drive_em(v);
        if (v.kind == K_ALU || v.kind == K_MIS) begin
            dgnt = 1'($urandom); drvalid = 1'($urandom); drdata = $urandom;
            @(negedge clk);
            check("nonmem_dreq", dreq, 0);
            check("nonmem_stall", mem_stall, 0);
            next_cycle();
        end else begin
            for (int c = 0; c <= v.gnt_dly; c++) begin
                dgnt = (c == v.gnt_dly); drvalid = 1'($urandom); drdata = $urandom;
                @(negedge clk);
                check("req_dreq", dreq, 1);
                check("req_dwe", dwe, v.kind == K_STORE);
                check("req_dbe", dbe, (v.kind == K_STORE) ? v.we : 4'hF);
                check("req_daddr", daddr, {v.addr[31:2], 2'b00});
                if (v.kind == K_STORE) check("req_dwdata", dwdata, v.wdata);
                check("req_stall", mem_stall, !(v.kind == K_STORE && c == v.gnt_dly));
                check("req_bubble", MW_wer_out, 0);
                next_cycle();
            end
            if (v.kind == K_LOAD) begin
                // Request fields were captured; upstream may present anything now.
                EM_daddr_in = $urandom; EM_funct3_in = 3'($urandom);
                EM_rd_in = 5'($urandom); EM_regdata_in = $urandom;
                for (int k = 1; k <= TO; k++) begin
                    hit = (k == v.rv_dly + 1);
                    drvalid = hit; dgnt = 1'($urandom);
                    drdata = hit ? v.rdata : $urandom;
                    @(negedge clk);
                    check("rv_dreq", dreq, 0);
                    check("rv_stall", mem_stall, !hit);
                    check("rv_bubble", MW_wer_out, 0);
                    next_cycle();
                    if (hit) break;
                end
            end
        end
        // Stray bus responses while idle must be ignored.
        drive_idle(); dgnt = 1'b1; drvalid = 1'b1; drdata = $urandom;
        @(negedge clk);
        check("res_wer", MW_wer_out, v.exp_wer);
        if (v.exp_wer) begin
            check("res_rd", MW_rd_out, v.exp_rd);
            check("res_wbdata", MW_wbdata_out, v.exp_wb);
        end
        check("res_misalign", mem_misalign_out, v.exp_mis);
        check("res_buserr", mem_buserr_out, v.exp_berr);
        check("res_stall", mem_stall, 0);
        check("res_dreq", dreq, 0);
        next_cycle();
        @(negedge clk);
        check("post_wer", MW_wer_out, 0);
        check("post_misalign", mem_misalign_out, 0);
        check("post_buserr", mem_buserr_out, 0);
        next_cycle();
    endtask

    task automatic reset_midflight();
        vec_t v;
        run_txn(mk(7'h33, 3'd0, 32'h0, 4'h0, 1'b1, 5'd17, 32'hA5A5_0001, 32'h0, 32'h0, 0, 0,
                   K_ALU, 1'b1, 5'd17, 32'hA5A5_0001, 1'b0, 1'b0));
        v = mk(OP_LOAD, F3_LW, 32'h400, 4'h0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0, 0, 0,
               K_LOAD, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        drive_em(v); dgnt = 1'b1; drvalid = 1'b0;
        @(negedge clk);
        check("rst_req_dreq", dreq, 1);
        next_cycle();
        dgnt = 1'b0;
        @(negedge clk);
        check("rst_wait_stall", mem_stall, 1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        drive_idle();
        @(negedge clk);
        check("rst_wer", MW_wer_out, 0);
        check("rst_rd", MW_rd_out, 0);
        check("rst_wbdata", MW_wbdata_out, 0);
        check("rst_misalign", mem_misalign_out, 0);
        check("rst_buserr", mem_buserr_out, 0);
        check("rst_dreq", dreq, 0);
        check("rst_dwe", dwe, 0);
        check("rst_stall", mem_stall, 0);
        next_cycle();
        drvalid = 1'b1; drdata = 32'h1111_2222;
        @(negedge clk);
        check("stray_stall", mem_stall, 0);
        check("stray_dreq", dreq, 0);
        next_cycle();
        drvalid = 1'b0;
        @(negedge clk);
        check("stray_wer", MW_wer_out, 0);
        check("stray_wbdata", MW_wbdata_out, 0);
        next_cycle();
    endtask

    initial begin
        vec_t table_q[$];

        // NOTE: stimulus is driven with blocking assignments just after the edge, away from sampling.
        rst_n = 1'b0;
        drive_idle();
        dgnt = 1'b0; drvalid = 1'b0; drdata = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("init_wer", MW_wer_out, 0);
        check("init_rd", MW_rd_out, 0);
        check("init_wbdata", MW_wbdata_out, 0);
        check("init_misalign", mem_misalign_out, 0);
        check("init_buserr", mem_buserr_out, 0);
        check("init_dreq", dreq, 0);
        check("init_dwe", dwe, 0);
        check("init_stall", mem_stall, 0);
        next_cycle();
        rst_n = 1'b1;

        //               op       f3    addr          we       wer   rd     regdata       wdata         rdata         gnt rv kind     ewer  erd    ewb           mis   berr
        table_q.push_back(mk(7'h33,  3'd0, 32'h0000_0000, 4'h0,    1'b1, 5'd5,  32'h0000_1234, 32'h0,        32'h0,         0, 0, K_ALU,   1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b0));
        table_q.push_back(mk(7'h23,  3'd2, 32'h0000_0100, 4'b0011, 1'b0, 5'd0,  32'h0,        32'h0000_BEEF, 32'h0,         2, 0, K_STORE, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd0, 32'h0000_0203, 4'h0,    1'b1, 5'd7,  32'h0,        32'h0,        32'h80FF_FF12, 0, 2, K_LOAD,  1'b1, 5'd7,  32'hFFFF_FF80, 1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd4, 32'h0000_0203, 4'h0,    1'b1, 5'd8,  32'h0,        32'h0,        32'h80FF_FF12, 0, 2, K_LOAD,  1'b1, 5'd8,  32'h0000_0080, 1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd1, 32'h0000_0202, 4'h0,    1'b1, 5'd9,  32'h0,        32'h0,        32'h8001_0000, 1, 0, K_LOAD,  1'b1, 5'd9,  32'hFFFF_8001, 1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd1, 32'h0000_0201, 4'h0,    1'b1, 5'd9,  32'h0,        32'h0,        32'h0,         0, 0, K_MIS,   1'b0, 5'd0,  32'h0,         1'b1, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd2, 32'h0000_0300, 4'h0,    1'b1, 5'd10, 32'h0,        32'h0,        32'h0,         1, 99, K_LOAD, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1));
        table_q.push_back(mk(OP_LOAD, 3'd5, 32'h0000_0202, 4'h0,    1'b1, 5'd11, 32'h0,        32'h0,        32'h8001_0000, 0, 1, K_LOAD,  1'b1, 5'd11, 32'h0000_8001, 1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd2, 32'h0000_0204, 4'h0,    1'b1, 5'd31, 32'h0,        32'h0,        32'hDEAD_BEEF, 0, 0, K_LOAD,  1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd2, 32'h0000_0206, 4'h0,    1'b1, 5'd12, 32'h0,        32'h0,        32'h0,         0, 0, K_MIS,   1'b0, 5'd0,  32'h0,         1'b1, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd3, 32'h0000_0208, 4'h0,    1'b1, 5'd13, 32'h0,        32'h0,        32'h1234_5678, 0, 3, K_LOAD,  1'b1, 5'd13, 32'h1234_5678, 1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd2, 32'h0000_020C, 4'hF,    1'b1, 5'd14, 32'h0,        32'hCAFE_F00D, 32'h0,         0, 0, K_STORE, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd0, 32'h0000_0000, 4'h0,    1'b0, 5'd3,  32'h0000_0055, 32'h0,       32'h0,         0, 0, K_ALU,   1'b0, 5'd0,  32'h0,         1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd0, 32'h0000_0200, 4'h0,    1'b1, 5'd15, 32'h0,        32'h0,        32'h0000_007F, 1, 1, K_LOAD,  1'b1, 5'd15, 32'h0000_007F, 1'b0, 1'b0));
        table_q.push_back(mk(OP_LOAD, 3'd1, 32'h0000_0200, 4'h0,    1'b1, 5'd16, 32'h0,        32'h0,        32'h1234_F00D, 0, 0, K_LOAD,  1'b1, 5'd16, 32'hFFFF_F00D, 1'b0, 1'b0));

        for (int i = 0; i < table_q.size(); i++) run_txn(table_q[i]);

        for (int i = 0; i < 300; i++) run_txn(rand_vec());

        reset_midflight();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
